// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encodings, parity modes and the
// clk_div clamp used by both uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Smallest usable bit period in clk cycles.
    localparam logic [3:0] CLK_DIV_MIN = 4'd2;

    // Effective bit period: 0 and 1 behave like the minimum.
    function automatic logic [3:0] eff_div(input logic [3:0] d);
        return (d < CLK_DIV_MIN) ? CLK_DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel byte handshake into the UART transmitter.
// tx_valid/tx_data from the source, tx_ready back from uart_tx.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit period counter: counts 0..P-1 while enabled, pulses o_bit_end at P-1.
// Ports: clk, i_clr (zero count, load i_period), i_en, i_period, o_bit_end.
module uart_bit_timer (
    input  logic       clk,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [3:0] i_period,
    output logic       o_bit_end
);
    logic [3:0] r_cnt;
    logic [3:0] r_per;

    // Terminal count is P-1, so a 4-bit counter never wraps.
    assign o_bit_end = i_en && (r_cnt == r_per - 4'd1);

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= 4'd0;
            r_per <= i_period;
        end else if (i_en) begin
            r_cnt <= o_bit_end ? 4'd0 : r_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS data (LSB first), optional parity,
// STOP_BITS stop bits. Ports: clk, rst, clk_div, s_tx (valid/data/ready),
// Tx_Serial, tx_busy, tx_done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] clk_div,
    uart_tx_if.slave   s_tx,
    output logic       Tx_Serial,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam logic [2:0] IDX_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] IDX_STOP_LAST = 3'(STOP_BITS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_nxt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] w_shreg_nxt;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_done_nxt;
    logic                 w_line;
    logic                 w_bit_end;

    assign Tx_Serial     = r_tx;
    assign tx_busy       = r_busy;
    assign tx_done       = r_done;
    assign s_tx.tx_ready = r_ready;

    // Period is latched at acceptance; later clk_div changes are ignored.
    uart_bit_timer u_timer (
        .clk       (clk),
        .i_clr     (rst || w_accept),
        .i_en      (r_state != S_IDLE),
        .i_period  (eff_div(clk_div)),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_line;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_shreg <= s_tx.tx_data;
                r_par   <= (PARITY == PAR_ODD) ? ~^s_tx.tx_data
                                               : ^s_tx.tx_data;
            end else begin
                r_shreg <= w_shreg_nxt;
            end
        end
    end

    // w_line is the level for the current state; it reaches the pin one
    // edge later, so the start bit appears the edge after acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        w_line      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_ready && s_tx.tx_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_line = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                w_line = r_shreg[0];
                if (w_bit_end) begin
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_idx == IDX_DATA_LAST) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = (PARITY != PAR_NONE) ? S_PARITY
                                                           : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                w_line = r_par;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_STOP_LAST) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end
endmodule
